// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, DATA_WIDTH bits LSB first,
// optional parity, 1 or 2 stop bits. The line is driven straight from a flop.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CLK_DIVIDE = CLK_FREQ / BAUD_RATE;
  localparam int DIV_W      = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
  localparam int IDX_W      = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIVIDE - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  ready_q;
  logic                  bit_end_s;
  logic                  accept_s;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
    return (^data) ^ (PARITY_ODD != 0);
  endfunction

  assign bit_end_s = (div_q == DIV_LAST);
  assign accept_s  = tx_valid && (state_q == S_IDLE);

  // State and datapath registers; reset lands in IDLE with the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      ready_q  <= (state_d == S_IDLE);
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_s) state_d = S_START; else state_d = S_IDLE;
      S_START:  if (bit_end_s) state_d = S_DATA; else state_d = S_START;
      S_DATA: begin
        if (bit_end_s && (idx_q == DATA_LAST)) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: if (bit_end_s) state_d = S_STOP; else state_d = S_PARITY;
      S_STOP: begin
        if (bit_end_s && (idx_q == STOP_LAST)) state_d = S_IDLE;
        else state_d = S_STOP;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Baud divider, bit index (data bits, then stop bits) and shift register.
  always_comb begin
    div_d    = div_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        idx_d = '0;
        if (accept_s) begin
          shift_d  = tx_data_in;
          parity_d = calc_parity(tx_data_in);
        end else begin
          shift_d  = shift_q;
        end
      end
      S_START, S_PARITY: begin
        div_d = bit_end_s ? '0 : div_q + DIV_W'(1);
        idx_d = '0;
      end
      S_DATA: begin
        div_d = bit_end_s ? '0 : div_q + DIV_W'(1);
        if (bit_end_s) begin
          shift_d = shift_q >> 1;
          idx_d   = (idx_q == DATA_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          idx_d   = idx_q;
        end
      end
      S_STOP: begin
        div_d = bit_end_s ? '0 : div_q + DIV_W'(1);
        if (bit_end_s) idx_d = (idx_q == STOP_LAST) ? '0 : idx_q + IDX_W'(1);
        else idx_d = idx_q;
      end
      default: begin
        div_d    = '0;
        idx_d    = '0;
        shift_d  = '0;
        parity_d = 1'b0;
      end
    endcase
  end

  // The line value is taken from the upcoming state so tx itself is a flop.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == S_STOP) && bit_end_s && (idx_q == STOP_LAST);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = ready_q;
  assign tx_busy  = !ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at CLK_DIVIDE=10,
// with a scoreboard of expected frames checked bit-by-bit by a line monitor.
module tb_uart_tx;

  typedef struct {
    logic [7:0] d;
    int         s;
    int         e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid_v;
  logic [7:0] data_v [4];
  logic [3:0] ready_v, tx_v, busy_v, done_v;

  int   cyc = 0;
  int   sel = 0;
  logic mon_en = 1'b0;
  logic mon_busy = 1'b0;
  logic mon_tx, mon_ready, mon_busy_o, mon_done;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.DATA_WIDTH(8), .CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(0),
            .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .tx_valid(valid_v[0]), .tx_data_in(data_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.DATA_WIDTH(8), .CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1),
            .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .tx_valid(valid_v[1]), .tx_data_in(data_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.DATA_WIDTH(8), .CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1),
            .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst), .tx_valid(valid_v[2]), .tx_data_in(data_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx #(.DATA_WIDTH(8), .CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(0),
            .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .tx_valid(valid_v[3]), .tx_data_in(data_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  always_comb begin
    mon_tx     = tx_v[sel];
    mon_ready  = ready_v[sel];
    mon_busy_o = busy_v[sel];
    mon_done   = done_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic send(input int s, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    sel        = s;
    valid_v[s] = 1'b1;
    data_v[s]  = d;
    @(posedge clk);
    #1;
    x.d = d; x.s = s; x.e = cyc;
    q.push_back(x);
    valid_v[s] = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !mon_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: each falling start edge pops one expected frame.
  initial begin
    exp_t cur;
    logic bits [12];
    int   hits [12];
    int   nb, fl, bad_hs, bad_done, pen, nst;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && mon_tx === 1'b0) begin
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          cur.d = 8'h00; cur.s = sel; cur.e = cyc;
        end else begin
          cur = q.pop_front();
        end
        check("start_cycle", cyc, cur.e);
        pen = (cur.s == 1 || cur.s == 2) ? 1 : 0;
        nst = (cur.s == 3) ? 2 : 1;
        nb  = 1 + 8 + pen + nst;
        fl  = nb * 10;
        bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) bits[1 + b] = cur.d[b];
        if (pen == 1) bits[9] = (^cur.d) ^ (cur.s == 2);
        for (int b = 9 + pen; b < nb; b++) bits[b] = 1'b1;
        for (int b = 0; b < 12; b++) hits[b] = 0;
        bad_hs = 0;
        bad_done = 0;
        for (int t = 0; t < fl; t++) begin
          if (t > 0) @(negedge clk);
          if (mon_tx === bits[t / 10]) hits[t / 10]++;
          if (mon_ready !== 1'b0 || mon_busy_o !== 1'b1) bad_hs++;
          if (mon_done !== 1'b0) bad_done++;
        end
        for (int b = 0; b < nb; b++) check($sformatf("bit%0d_clocks", b), hits[b], 32'd10);
        check("ready_busy_in_frame", bad_hs, 32'd0);
        check("done_in_frame", bad_done, 32'd0);
        @(negedge clk);
        check("done_pulse", mon_done, 32'd1);
        check("ready_after", mon_ready, 32'd1);
        check("busy_after", mon_busy_o, 32'd0);
        check("tx_after", mon_tx, 32'd1);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   e;
    int   lows;
    logic [7:0] r;
    rst = 1'b0;
    valid_v = 4'b0000;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

    // Reset asserted between clock edges must act at once.
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", tx_v[i], 32'd1);
      check("rst_ready", ready_v[i], 32'd1);
      check("rst_busy", busy_v[i], 32'd0);
      check("rst_done", done_v[i], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'hA5); wait_idle();
    send(1, 8'h07); wait_idle();
    send(2, 8'h07); wait_idle();
    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom_range(0, 255));
      send(1, r); wait_idle();
      send(2, r); wait_idle();
    end

    // 8N2 back-to-back with tx_valid held high.
    begin
      exp_t x;
      @(negedge clk);
      sel = 3;
      valid_v[3] = 1'b1;
      data_v[3]  = 8'h00;
      @(posedge clk);
      #1;
      e = cyc;
      x.d = 8'h00; x.s = 3; x.e = e;       q.push_back(x);
      x.d = 8'hFF; x.s = 3; x.e = e + 111; q.push_back(x);
      data_v[3] = 8'hFF;
      repeat (111) @(posedge clk);
      #1;
      valid_v[3] = 1'b0;
      wait_idle();
    end

    // Busy rejection: extra request mid-frame is dropped.
    send(0, 8'h81);
    e = q[0].e;
    while (cyc < e + 39) @(negedge clk);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h3C;
    @(negedge clk);
    valid_v[0] = 1'b0;
    wait_idle();
    repeat (150) @(negedge clk);
    check("no_queued_frame", q.size(), 32'd0);

    // Reset during data bit 3 of 0xF7 (bit 3 is 0).
    mon_en = 1'b0;
    @(negedge clk);
    sel = 0;
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hF7;
    @(posedge clk);
    #1;
    e = cyc;
    valid_v[0] = 1'b0;
    while (cyc < e + 44) @(negedge clk);
    check("midrst_pre_tx", tx_v[0], 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", tx_v[0], 32'd1);
    check("midrst_ready", ready_v[0], 32'd1);
    check("midrst_busy", busy_v[0], 32'd0);
    check("midrst_done", done_v[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", ready_v[0], 32'd1);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) lows++;
    end
    check("no_resume", lows, 32'd0);
    mon_en = 1'b1;
    send(0, 8'h5A); wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter. It accepts a parallel byte over a valid/ready handshake and drives one asynchronous serial frame on `tx`: start bit, data LSB first, optional parity, then 1 or 2 stop bits. It is the transmit-side counterpart to the existing UART receive path in the UART subsystem and shares its framing and baud-divider convention.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 19200: serial bit rate.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits. Legal values are 1 and 2.

- `clk` input 1: system clock. This is the only clock.
- `rst` input 1: asynchronous reset, active-high.
- `tx_valid` input 1: `tx_data_in` is valid and a transmit is requested.
- `tx_data_in` input DATA_WIDTH: byte to send.
- `tx_ready` output 1: block can accept a byte. High only in IDLE.
- `tx` output 1: serial line. Idles high. Registered.
- `tx_busy` output 1: a frame is in progress (any state other than IDLE).
- `tx_done` output 1: one-cycle pulse after the last stop bit completes.

## Operation
- `CLK_DIVIDE` = CLK_FREQ / BAUD_RATE, using integer (truncating) division. Each serial bit is held for exactly `CLK_DIVIDE` clocks.
- Divider counter: `$clog2(CLK_DIVIDE)` bits. Counts 0 to CLK_DIVIDE-1, then wraps to 0 at the end of each bit.
- Bit index counter: `$clog2(DATA_WIDTH)`+1 bits.
- Handshake: a transfer is accepted on a rising edge where `tx_valid`=1 and `tx_ready`=1.
  - `tx_data_in` is latched into a shift register on that edge.
  - The parity bit is computed from the latched byte: XOR of all data bits, XORed with `PARITY_ODD`.
- `tx_valid` while busy is ignored. It is not queued.
- `tx_data_in` changes after acceptance have no effect on the frame in progress.
- States:
  - IDLE: `tx`=1, `tx_ready`=1. Goes to START on acceptance.
  - START: `tx`=0 for CLK_DIVIDE clocks, then DATA.
  - DATA: `tx` = shift register bit 0. After each CLK_DIVIDE clocks, shift right and increment the index. After DATA_WIDTH bits, go to PARITY if `PARITY_EN`=1, else STOP.
  - PARITY: `tx` = parity bit for CLK_DIVIDE clocks, then STOP.
  - STOP: `tx`=1 for STOP_BITS×CLK_DIVIDE clocks, then IDLE, asserting `tx_done` for one cycle.
  - Illegal state encodings go to IDLE with `tx`=1.
- Reset, including mid-frame: all registers clear immediately and asynchronously.
  - State goes to IDLE; `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - Counters and shift register go to 0.
  - A truncated frame is not resumed after reset.

## Timing
- Accept edge at cycle 0. `tx` falls to 0 for the first time in the cycle after that edge; the start bit spans cycles 1..CLK_DIVIDE.
- Total frame length F = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLK_DIVIDE clocks, covering cycles 1..F.
- At cycle F+1:
  - `tx_done`=1 and `tx_ready`=1 in the same cycle.
  - `tx_busy`=0 in that cycle.
  - `tx` remains 1.
- Back-to-back: if `tx_valid` is held high, the next frame is accepted on the edge at the end of cycle F+1. This gives a minimum inter-frame idle of exactly 1 clock of `tx`=1.
- `tx_busy` = !`tx_ready` at all times. Both are derived from registered state, with no combinational path from `tx_valid`.
- `tx` is glitch-free: driven directly from a flop.

## Test plan
All scenarios use CLK_FREQ=1000 and BAUD_RATE=100, so CLK_DIVIDE=10.
- Reset: assert `rst` mid-clock with no edge.
  - Required: immediately `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
- 8N1, byte 0xA5:
  - `tx` sequence, 10 clocks each: 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_done` pulses at cycle 101; `tx_ready` is high at cycle 101.
- 8E1, byte 0x07: parity bit = 1, and the frame is 110 clocks. With `PARITY_ODD`=1, the same byte gives parity bit = 0.
- 8N2, byte 0x00, back-to-back with 0xFF and `tx_valid` held high:
  - First frame: 110 clocks.
  - Exactly 1 idle-high clock, then the second start bit.
  - 0xFF data bits are all 1.
- Busy rejection: pulse `tx_valid` with 0x3C at cycle 40 of a 0x81 frame, and change `tx_data_in`.
  - Required: the 0x81 frame is unaltered and no second frame is sent.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - Required: `tx` returns to 1 asynchronously.
  - After release: `tx_ready`=1, and the next accepted 0x5A produces a complete, correct frame.
